uart_rx_buffer: RTL and testbench

- Receive-side buffer directly downstream of the UART RX frame controller; consumes its parallel byte (P_DATA) and frame-valid strobe (Data_valid).
- Stores received bytes in a first-word-fall-through FIFO and presents them on a ready/valid read port to the host logic.
- Tracks overrun (byte lost while full) and keeps saturating counters of parity and stop-bit errors, giving software link-health visibility.

---
 rtl/uart_rx_buffer.sv | 97 +++++++++
 tb/tb_uart_rx_buffer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffer.sv
// Receive-side byte buffer: rising-edge detection of the RX controller strobes,
// a first-word-fall-through FIFO, a sticky overrun flag and saturating error counters.
module uart_rx_buffer #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 8,
  parameter int ADDR_WIDTH    = 3,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [DATA_WIDTH-1:0]    P_DATA,
  input  logic                     Data_valid,
  input  logic                     Parity_ERR,
  input  logic                     Stp_ERR,
  input  logic                     Rd_ready,
  input  logic                     Clr_status,
  output logic [DATA_WIDTH-1:0]    Rd_data,
  output logic                     Rd_valid,
  output logic                     Full,
  output logic [ADDR_WIDTH:0]      Fifo_count,
  output logic                     Overrun,
  output logic [ERR_CNT_WIDTH-1:0] Par_err_cnt,
  output logic [ERR_CNT_WIDTH-1:0] Stp_err_cnt
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
  logic                  dv_q, par_q, stp_q;
  logic                  dv_evt, par_evt, stp_evt;
  logic                  empty, push, pop, drop;

  // One event per rising edge, however long the upstream level is held.
  assign dv_evt  = Data_valid & ~dv_q;
  assign par_evt = Parity_ERR & ~par_q;
  assign stp_evt = Stp_ERR & ~stp_q;

  assign empty = (wr_ptr == rd_ptr);
  assign Full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                 (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign pop   = ~empty & Rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push  = dv_evt & (~Full | pop);
  assign drop  = dv_evt & Full & ~pop;

  assign Rd_valid   = ~empty;
  assign Rd_data    = mem[rd_ptr[ADDR_WIDTH-1:0]];
  assign Fifo_count = wr_ptr - rd_ptr;

  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= P_DATA;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      dv_q   <= 1'b0;
      par_q  <= 1'b0;
      stp_q  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      dv_q  <= Data_valid;
      par_q <= Parity_ERR;
      stp_q <= Stp_ERR;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Status: a new event in the clear cycle takes priority over the clear.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Overrun     <= 1'b0;
      Par_err_cnt <= '0;
      Stp_err_cnt <= '0;
    end else begin
      if (drop)            Overrun <= 1'b1;
      else if (Clr_status) Overrun <= 1'b0;

      if (par_evt) begin
        if (Clr_status)             Par_err_cnt <= ERR_CNT_WIDTH'(1);
        else if (Par_err_cnt != '1) Par_err_cnt <= Par_err_cnt + ERR_CNT_WIDTH'(1);
      end else if (Clr_status) begin
        Par_err_cnt <= '0;
      end

      if (stp_evt) begin
        if (Clr_status)             Stp_err_cnt <= ERR_CNT_WIDTH'(1);
        else if (Stp_err_cnt != '1) Stp_err_cnt <= Stp_err_cnt + ERR_CNT_WIDTH'(1);
      end else if (Clr_status) begin
        Stp_err_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed self-checking bench for uart_rx_buffer with hand-computed expectations.
module tb_uart_rx_buffer;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [7:0] P_DATA;
  logic       Data_valid, Parity_ERR, Stp_ERR, Rd_ready, Clr_status;
  logic [7:0] Rd_data;
  logic       Rd_valid, Full, Overrun;
  logic [3:0] Fifo_count;
  logic [7:0] Par_err_cnt, Stp_err_cnt;

  int tests = 0;
  int fails = 0;

  uart_rx_buffer dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .P_DATA      (P_DATA),
    .Data_valid  (Data_valid),
    .Parity_ERR  (Parity_ERR),
    .Stp_ERR     (Stp_ERR),
    .Rd_ready    (Rd_ready),
    .Clr_status  (Clr_status),
    .Rd_data     (Rd_data),
    .Rd_valid    (Rd_valid),
    .Full        (Full),
    .Fifo_count  (Fifo_count),
    .Overrun     (Overrun),
    .Par_err_cnt (Par_err_cnt),
    .Stp_err_cnt (Stp_err_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      $error("%s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] d);
    P_DATA     = d;
    Data_valid = 1'b1;
    tick();
    Data_valid = 1'b0;
    tick();
  endtask

  initial begin
    Rst = 1'b1; P_DATA = '0; Data_valid = 0; Parity_ERR = 0; Stp_ERR = 0;
    Rd_ready = 0; Clr_status = 0;
    #2 Rst = 1'b0;
    tick(); tick();
    check("rst_valid", Rd_valid, 0);
    check("rst_full", Full, 0);
    check("rst_count", Fifo_count, 0);
    check("rst_overrun", Overrun, 0);
    check("rst_par", Par_err_cnt, 0);
    check("rst_stp", Stp_err_cnt, 0);
    #2 Rst = 1'b1;
    tick();

    // three bytes, then drain in order
    pulse(8'h11); pulse(8'h22); pulse(8'h33);
    check("t1_count", Fifo_count, 3);
    check("t1_valid", Rd_valid, 1);
    check("t1_head", Rd_data, 8'h11);
    Rd_ready = 1'b1;
    tick(); check("t1_rd2", Rd_data, 8'h22); check("t1_cnt2", Fifo_count, 2);
    tick(); check("t1_rd3", Rd_data, 8'h33);
    tick(); check("t1_empty", Rd_valid, 0); check("t1_cnt0", Fifo_count, 0);
    tick(); check("t1_ign_rd", Fifo_count, 0);
    Rd_ready = 1'b0;

    // held strobe stores one byte
    P_DATA = 8'hA5; Data_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    Data_valid = 1'b0;
    tick();
    check("t2_count", Fifo_count, 1);
    check("t2_data", Rd_data, 8'hA5);
    Rd_ready = 1'b1; tick(); Rd_ready = 1'b0;
    check("t2_drain", Rd_valid, 0);

    // fill, overrun, clear priority, push with pop while full
    for (int i = 0; i < 8; i++) pulse(8'(i));
    check("t3_full", Full, 1);
    check("t3_count8", Fifo_count, 8);
    check("t3_noovr", Overrun, 0);
    pulse(8'hFF);
    check("t3_overrun", Overrun, 1);
    check("t3_cnt_ovr", Fifo_count, 8);
    check("t3_head_ovr", Rd_data, 8'h00);
    Clr_status = 1'b1; tick(); Clr_status = 1'b0;
    check("t3_ovr_clr", Overrun, 0);
    P_DATA = 8'hFF; Data_valid = 1'b1; Clr_status = 1'b1;
    tick();
    Data_valid = 1'b0; Clr_status = 1'b0;
    check("t3_ovr_wins", Overrun, 1);
    tick();
    Clr_status = 1'b1; tick(); Clr_status = 1'b0;
    check("t3_ovr_clr2", Overrun, 0);
    P_DATA = 8'hFF; Data_valid = 1'b1; Rd_ready = 1'b1;
    tick();
    Data_valid = 1'b0; Rd_ready = 1'b0;
    tick();
    check("t3_pp_count", Fifo_count, 8);
    check("t3_pp_full", Full, 1);
    check("t3_pp_head", Rd_data, 8'h01);
    check("t3_pp_noovr", Overrun, 0);
    Rd_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check("t3_drain", Rd_data, 16'(i));
      tick();
    end
    check("t3_last", Rd_data, 8'hFF);
    tick();
    Rd_ready = 1'b0;
    check("t3_empty", Rd_valid, 0);

    // 20 push/pop pairs across the pointer wrap
    for (int i = 0; i < 20; i++) begin
      pulse(8'h40 + 8'(i));
      check("t4_count", Fifo_count, 1);
      check("t4_data", Rd_data, 16'h40 + 16'(i));
      Rd_ready = 1'b1; tick(); Rd_ready = 1'b0;
      check("t4_cnt0", Fifo_count, 0);
    end

    // error counters
    for (int i = 0; i < 3; i++) begin
      Parity_ERR = 1'b1; tick(); Parity_ERR = 1'b0; tick();
    end
    check("t5_par3", Par_err_cnt, 3);
    Parity_ERR = 1'b1; Stp_ERR = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    Parity_ERR = 1'b0; Stp_ERR = 1'b0; tick();
    check("t5_par4", Par_err_cnt, 4);
    check("t5_stp1", Stp_err_cnt, 1);
    Clr_status = 1'b1; tick(); Clr_status = 1'b0;
    check("t5_clr_par", Par_err_cnt, 0);
    check("t5_clr_stp", Stp_err_cnt, 0);
    for (int i = 0; i < 260; i++) begin
      Parity_ERR = 1'b1; tick(); Parity_ERR = 1'b0; tick();
    end
    check("t5_par_sat", Par_err_cnt, 255);
    check("t5_stp0", Stp_err_cnt, 0);
    Clr_status = 1'b1; tick(); Clr_status = 1'b0;
    check("t5_par_clr", Par_err_cnt, 0);
    Stp_ERR = 1'b1; Clr_status = 1'b1; tick();
    Stp_ERR = 1'b0; Clr_status = 1'b0; tick();
    check("t5_stp_wins", Stp_err_cnt, 1);

    // asynchronous reset with data stored
    pulse(8'h81); pulse(8'h82); pulse(8'h83); pulse(8'h84);
    check("t6_count4", Fifo_count, 4);
    @(posedge Clk);
    #3 Rst = 1'b0;
    #1;
    check("t6_rst_valid", Rd_valid, 0);
    check("t6_rst_count", Fifo_count, 0);
    check("t6_rst_ovr", Overrun, 0);
    check("t6_rst_stp", Stp_err_cnt, 0);
    #2 Rst = 1'b1;
    tick();
    pulse(8'h5A);
    check("t6_count1", Fifo_count, 1);
    check("t6_data", Rd_data, 8'h5A);
    check("t6_valid", Rd_valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
